// File: rtl/quad_enc_pkg.sv
// Shared definitions for the quadrature encoder array: Gray states and step decode.
package quad_enc_pkg;

  // Accepted {A,B} levels in forward rotation order 00 -> 01 -> 11 -> 10 -> 00
  localparam logic [1:0] QS_00 = 2'b00;
  localparam logic [1:0] QS_01 = 2'b01;
  localparam logic [1:0] QS_11 = 2'b11;
  localparam logic [1:0] QS_10 = 2'b10;

  typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DN, STEP_ERR} step_e;

  function automatic logic [1:0] gray_next(input logic [1:0] s);
    case (s)
      QS_00:   gray_next = QS_01;
      QS_01:   gray_next = QS_11;
      QS_11:   gray_next = QS_10;
      default: gray_next = QS_00;
    endcase
  endfunction

  // Classify a prev -> cur transition; both bits flipping is an illegal jump
  function automatic step_e quad_step(input logic [1:0] prev, input logic [1:0] cur);
    if (cur == prev)                 quad_step = STEP_NONE;
    else if (cur == gray_next(prev)) quad_step = STEP_UP;
    else if (prev == gray_next(cur)) quad_step = STEP_DN;
    else                             quad_step = STEP_ERR;
  endfunction

endpackage

// File: rtl/quad_enc_if.sv
// Pad-side and host-side signal bundle of the quadrature encoder array.
interface quad_enc_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] enc_a;
  logic [NUM_CH-1:0] enc_b;
  logic [NUM_CH-1:0] cnt_clr;
  logic [NUM_CH-1:0] err_clr;
  logic              capture;
  logic [SEL_W-1:0]  rd_sel;
  logic [CNT_W-1:0]  rd_count;
  logic              rd_dir;
  logic              cap_valid;
  logic [NUM_CH-1:0] err;

  modport master (
    output enc_a, enc_b, cnt_clr, err_clr, capture, rd_sel,
    input  rd_count, rd_dir, cap_valid, err
  );

  modport slave (
    input  enc_a, enc_b, cnt_clr, err_clr, capture, rd_sel,
    output rd_count, rd_dir, cap_valid, err
  );
endinterface

// File: rtl/quad_enc_channel.sv
// One encoder channel: 2-flop sync, per-bit glitch filter, x4 decode, signed counter, sticky error.
module quad_enc_channel
  import quad_enc_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 3,
  parameter int SATURATE = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             cnt_clr,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             err
);
  localparam int FW     = $clog2(FILT_LEN + 1);
  localparam int SETTLE = 2 + FILT_LEN;
  localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

  logic [1:0]          sync1, sync2, acc, acc_nxt;
  logic [1:0][FW-1:0]  fcnt, fcnt_nxt;
  logic [4:0]          settle;
  logic                primed;
  step_e               step;

  // Filter: a bit flips only after FILT_LEN consecutive differing samples
  always_comb begin
    acc_nxt  = acc;
    fcnt_nxt = fcnt;
    for (int i = 0; i < 2; i++) begin
      if (sync2[i] == acc[i]) begin
        fcnt_nxt[i] = '0;
      end else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
        acc_nxt[i]  = sync2[i];
        fcnt_nxt[i] = '0;
      end else begin
        fcnt_nxt[i] = fcnt[i] + 1'b1;
      end
    end
  end

  // Decode against the level being accepted this edge, so the count moves on the
  // same edge the filter accepts. Until the sync+filter pipeline has refilled after
  // reset, the accepted level is just the initial prev and must not step or flag.
  assign primed = (settle == 5'(SETTLE));
  assign step   = primed ? quad_step(acc, acc_nxt) : STEP_NONE;

  // Synchroniser, filter state and post-reset settle counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      acc    <= '0;
      fcnt   <= '0;
      settle <= '0;
    end else begin
      sync1 <= {enc_a, enc_b};
      sync2 <= sync1;
      acc   <= acc_nxt;
      fcnt  <= fcnt_nxt;
      if (!primed) settle <= settle + 5'd1;
    end
  end

  // Position counter and direction; clear beats a step in the same cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      dir   <= 1'b0;
    end else if (cnt_clr) begin
      count <= '0;
    end else begin
      case (step)
        STEP_UP: begin
          dir <= 1'b1;
          if (!(SATURATE != 0 && count == CNT_MAX)) count <= count + CNT_W'(1);
        end
        STEP_DN: begin
          dir <= 1'b0;
          if (!(SATURATE != 0 && count == CNT_MIN)) count <= count - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Sticky illegal-jump flag; a new event wins over a clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              err <= 1'b0;
    else if (step == STEP_ERR) err <= 1'b1;
    else if (err_clr)          err <= 1'b0;
  end
endmodule

// File: rtl/quad_encoder_array.sv
// Multi-channel quadrature decoder: channel array, atomic snapshot bank, registered readout.
module quad_encoder_array
  import quad_enc_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int FILT_LEN = 3,
  parameter int SATURATE = 0
) (
  input logic      clock,
  input logic      reset_n,
  quad_enc_if.slave bus
);
  logic [NUM_CH-1:0][CNT_W-1:0] count, snap;
  logic [NUM_CH-1:0]            dir;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    quad_enc_channel #(
      .CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .SATURATE(SATURATE)
    ) u_ch (
      .clock   (clock),
      .reset_n (reset_n),
      .enc_a   (bus.enc_a[g]),
      .enc_b   (bus.enc_b[g]),
      .cnt_clr (bus.cnt_clr[g]),
      .err_clr (bus.err_clr[g]),
      .count   (count[g]),
      .dir     (dir[g]),
      .err     (bus.err[g])
    );
  end

  // Snapshot all channels together; values are those held before this edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snap          <= '0;
      bus.cap_valid <= 1'b0;
    end else begin
      bus.cap_valid <= bus.capture;
      if (bus.capture) snap <= count;
    end
  end

  // Readout mux; unpopulated selector codes read as zero
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.rd_count <= '0;
      bus.rd_dir   <= 1'b0;
    end else if (int'(bus.rd_sel) < NUM_CH) begin
      bus.rd_count <= snap[bus.rd_sel];
      bus.rd_dir   <= dir[bus.rd_sel];
    end else begin
      bus.rd_count <= '0;
      bus.rd_dir   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_quad_encoder_array.sv
// Bench for quad_encoder_array: main 4ch/16-bit wrap DUT plus 4-bit wrap and saturate DUTs.
module tb_quad_encoder_array;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  quad_enc_if #(.NUM_CH(4), .CNT_W(16)) m_if ();
  quad_enc_if #(.NUM_CH(3), .CNT_W(4))  w_if ();
  quad_enc_if #(.NUM_CH(3), .CNT_W(4))  s_if ();

  quad_encoder_array #(.NUM_CH(4), .CNT_W(16), .FILT_LEN(3), .SATURATE(0)) dut (
    .clock(clock), .reset_n(reset_n), .bus(m_if.slave));
  quad_encoder_array #(.NUM_CH(3), .CNT_W(4), .FILT_LEN(3), .SATURATE(0)) dut_w (
    .clock(clock), .reset_n(reset_n), .bus(w_if.slave));
  quad_encoder_array #(.NUM_CH(3), .CNT_W(4), .FILT_LEN(3), .SATURATE(1)) dut_s (
    .clock(clock), .reset_n(reset_n), .bus(s_if.slave));

  typedef struct packed { logic [15:0] cnt; logic dir; } exp_t;
  typedef struct packed { logic [3:0]  cnt; logic dir; } sexp_t;
  exp_t  q_m[$];
  sexp_t q_w[$], q_s[$];

  int errors = 0, checks = 0;
  int pos[4], exp_cnt[4];
  bit exp_dir[4];
  int spos, w_cnt, s_cnt;
  bit sdir;

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [1:0] gray(input int p);
    case (p & 3)
      0: gray = 2'b00;
      1: gray = 2'b01;
      2: gray = 2'b11;
      default: gray = 2'b10;
    endcase
  endfunction

  task automatic set_pins(input int ch);
    logic [1:0] g;
    g = gray(pos[ch]);
    m_if.enc_a[ch] = g[1];
    m_if.enc_b[ch] = g[0];
  endtask

  task automatic move(input int ch, input bit up);
    pos[ch] = (pos[ch] + (up ? 1 : 3)) % 4;
    set_pins(ch);
    exp_cnt[ch] = (exp_cnt[ch] + (up ? 1 : -1)) & 32'hFFFF;
    exp_dir[ch] = up;
    ticks(6);
  endtask

  task automatic move_small(input bit up);
    logic [1:0] g;
    spos = (spos + (up ? 1 : 3)) % 4;
    g = gray(spos);
    w_if.enc_a[0] = g[1]; w_if.enc_b[0] = g[0];
    s_if.enc_a[0] = g[1]; s_if.enc_b[0] = g[0];
    w_cnt = (w_cnt + (up ? 1 : -1)) & 15;
    s_cnt = s_cnt + (up ? 1 : -1);
    if (s_cnt > 7)  s_cnt = 7;
    if (s_cnt < -8) s_cnt = -8;
    sdir = up;
    ticks(6);
  endtask

  task automatic cap_main(input int ch);
    exp_t e;
    int n;
    m_if.rd_sel = 2'(ch);
    e.cnt = exp_cnt[ch][15:0];
    e.dir = exp_dir[ch];
    q_m.push_back(e);
    m_if.capture = 1'b1; tick(); m_if.capture = 1'b0;
    n = 0;
    while (m_if.cap_valid !== 1'b1 && n < 4) begin tick(); n++; end
    checks++;
    if (m_if.cap_valid !== 1'b1) begin
      errors++; $display("FAIL cap_valid_timeout ch%0d got %b want 1", ch, m_if.cap_valid);
    end
    tick();
    e = q_m.pop_front();
    checks++;
    if (m_if.rd_count !== e.cnt) begin
      errors++; $display("FAIL rd_count ch%0d got %h want %h", ch, m_if.rd_count, e.cnt);
    end
    checks++;
    if (m_if.rd_dir !== e.dir) begin
      errors++; $display("FAIL rd_dir ch%0d got %b want %b", ch, m_if.rd_dir, e.dir);
    end
  endtask

  task automatic cap_small(input int sel);
    sexp_t ew, es;
    int n;
    w_if.rd_sel = 2'(sel);
    s_if.rd_sel = 2'(sel);
    ew.cnt = (sel == 0) ? w_cnt[3:0] : 4'h0;
    ew.dir = (sel == 0) ? sdir : 1'b0;
    es.cnt = (sel == 0) ? s_cnt[3:0] : 4'h0;
    es.dir = ew.dir;
    q_w.push_back(ew);
    q_s.push_back(es);
    w_if.capture = 1'b1; s_if.capture = 1'b1; tick();
    w_if.capture = 1'b0; s_if.capture = 1'b0;
    n = 0;
    while (w_if.cap_valid !== 1'b1 && n < 4) begin tick(); n++; end
    checks++;
    if (w_if.cap_valid !== 1'b1) begin
      errors++; $display("FAIL small_cap_timeout sel%0d got %b want 1", sel, w_if.cap_valid);
    end
    tick();
    ew = q_w.pop_front();
    es = q_s.pop_front();
    checks++;
    if (w_if.rd_count !== ew.cnt) begin
      errors++; $display("FAIL wrap_count sel%0d got %h want %h", sel, w_if.rd_count, ew.cnt);
    end
    checks++;
    if (s_if.rd_count !== es.cnt) begin
      errors++; $display("FAIL sat_count sel%0d got %h want %h", sel, s_if.rd_count, es.cnt);
    end
    checks++;
    if (w_if.rd_dir !== ew.dir || s_if.rd_dir !== es.dir) begin
      errors++; $display("FAIL small_dir sel%0d got %b/%b want %b/%b", sel, w_if.rd_dir, s_if.rd_dir, ew.dir, es.dir);
    end
  endtask

  task automatic test_reset();
    ticks(2);
    checks++;
    if (m_if.rd_count !== 16'h0 || m_if.rd_dir !== 1'b0 || m_if.cap_valid !== 1'b0 || m_if.err !== 4'h0) begin
      errors++; $display("FAIL reset_outputs got cnt=%h dir=%b cv=%b err=%b want 0", m_if.rd_count, m_if.rd_dir, m_if.cap_valid, m_if.err);
    end
    #2 reset_n = 1'b1;
    ticks(10);
    checks++;
    if (m_if.err !== 4'h0) begin
      errors++; $display("FAIL reset_err_idle got %b want 0000", m_if.err);
    end
  endtask

  task automatic test_forward();
    for (int i = 0; i < 8; i++) move(0, 1'b1);
    cap_main(0);
  endtask

  task automatic test_reverse();
    for (int i = 0; i < 3; i++) move(1, 1'b0);
    cap_main(1);
    checks++;
    if (m_if.err[1] !== 1'b0) begin
      errors++; $display("FAIL reverse_err got %b want 0", m_if.err[1]);
    end
  endtask

  task automatic test_glitch_illegal();
    m_if.enc_a[2] = 1'b1; ticks(2); m_if.enc_a[2] = 1'b0;
    ticks(8);
    cap_main(2);
    pos[2] = 2; set_pins(2); ticks(6);
    checks++;
    if (m_if.err[2] !== 1'b1) begin
      errors++; $display("FAIL illegal_err got %b want 1", m_if.err[2]);
    end
    cap_main(2);
    pos[2] = 0; set_pins(2); ticks(4);
    m_if.err_clr[2] = 1'b1; tick(); m_if.err_clr[2] = 1'b0;
    checks++;
    if (m_if.err[2] !== 1'b1) begin
      errors++; $display("FAIL err_set_wins got %b want 1", m_if.err[2]);
    end
    m_if.err_clr[2] = 1'b1; tick(); m_if.err_clr[2] = 1'b0;
    checks++;
    if (m_if.err !== 4'b0000) begin
      errors++; $display("FAIL err_clear got %b want 0000", m_if.err);
    end
  endtask

  task automatic test_wrap_sat();
    for (int i = 0; i < 7; i++) move_small(1'b1);
    cap_small(0);
    move_small(1'b1);
    cap_small(0);
    for (int i = 0; i < 17; i++) move_small(1'b0);
    cap_small(0);
    cap_small(3);
  endtask

  task automatic test_clr_capture();
    exp_t e;
    pos[0] = (pos[0] + 1) % 4; set_pins(0); ticks(4);
    m_if.cnt_clr[0] = 1'b1; tick(); m_if.cnt_clr[0] = 1'b0;
    exp_cnt[0] = 0; exp_dir[0] = 1'b1;
    ticks(3);
    cap_main(0);
    pos[0] = (pos[0] + 1) % 4; set_pins(0); ticks(4);
    m_if.rd_sel = 2'd0;
    e.cnt = exp_cnt[0][15:0]; e.dir = exp_dir[0];
    q_m.push_back(e);
    m_if.capture = 1'b1; tick(); m_if.capture = 1'b0;
    exp_cnt[0] = 1;
    checks++;
    if (m_if.cap_valid !== 1'b1) begin
      errors++; $display("FAIL cap_pulse_high got %b want 1", m_if.cap_valid);
    end
    tick();
    checks++;
    if (m_if.cap_valid !== 1'b0) begin
      errors++; $display("FAIL cap_pulse_low got %b want 0", m_if.cap_valid);
    end
    e = q_m.pop_front();
    checks++;
    if (m_if.rd_count !== e.cnt) begin
      errors++; $display("FAIL cap_prestep got %h want %h", m_if.rd_count, e.cnt);
    end
    cap_main(0);
  endtask

  task automatic test_back_to_back();
    m_if.capture = 1'b1; tick();
    checks++;
    if (m_if.cap_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_first got %b want 1", m_if.cap_valid);
    end
    tick(); m_if.capture = 1'b0;
    checks++;
    if (m_if.cap_valid !== 1'b1) begin
      errors++; $display("FAIL b2b_second got %b want 1", m_if.cap_valid);
    end
    tick();
    checks++;
    if (m_if.cap_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_end got %b want 0", m_if.cap_valid);
    end
  endtask

  task automatic test_reset_midmotion();
    pos[3] = 2; set_pins(3); ticks(6);
    checks++;
    if (m_if.err[3] !== 1'b1) begin
      errors++; $display("FAIL pre_reset_err got %b want 1", m_if.err[3]);
    end
    cap_main(0);
    pos[0] = (pos[0] + 1) % 4; set_pins(0); ticks(2);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (m_if.rd_count !== 16'h0 || m_if.rd_dir !== 1'b0 || m_if.cap_valid !== 1'b0 || m_if.err !== 4'h0) begin
      errors++; $display("FAIL async_reset got cnt=%h dir=%b cv=%b err=%b want 0", m_if.rd_count, m_if.rd_dir, m_if.cap_valid, m_if.err);
    end
    ticks(3);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin exp_cnt[i] = 0; exp_dir[i] = 1'b0; end
    ticks(10);
    checks++;
    if (m_if.err !== 4'h0) begin
      errors++; $display("FAIL post_reset_err got %b want 0000", m_if.err);
    end
    cap_main(3);
    cap_main(0);
    move(0, 1'b1);
    cap_main(0);
  endtask

  initial begin
    m_if.enc_a = '0; m_if.enc_b = '0; m_if.cnt_clr = '0; m_if.err_clr = '0;
    m_if.capture = 1'b0; m_if.rd_sel = '0;
    w_if.enc_a = '0; w_if.enc_b = '0; w_if.cnt_clr = '0; w_if.err_clr = '0;
    w_if.capture = 1'b0; w_if.rd_sel = '0;
    s_if.enc_a = '0; s_if.enc_b = '0; s_if.cnt_clr = '0; s_if.err_clr = '0;
    s_if.capture = 1'b0; s_if.rd_sel = '0;
    for (int i = 0; i < 4; i++) begin pos[i] = 0; exp_cnt[i] = 0; exp_dir[i] = 1'b0; end
    spos = 0; w_cnt = 0; s_cnt = 0; sdir = 1'b0;
    test_reset();
    test_forward();
    test_reverse();
    test_glitch_illegal();
    test_wrap_sat();
    test_clr_capture();
    test_back_to_back();
    test_reset_midmotion();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "timeout");
  end
endmodule
